tick_gen: RTL

Parametrised multi-channel tick generator, successor to the fixed 100 MHz→1 Hz divider. A shared prescaler derives a base strobe at BASE_HZ from the system clock. N_CH independent channel dividers produce one-cycle tick pulses and 50 % square waves. Consumers are the seconds counter, the setting-mode blink and the display scan. Divisors are runtime-reprogrammable with glitch-free application at the channel wrap, and a sync clear realigns all phases, e.g. when the user sets the time.

---
 rtl/tick_gen_pkg.sv | 18 +
 rtl/tick_chan.sv | 78 +++++++
 rtl/tick_gen.sv | 102 ++++++++++
 3 files changed

// File: rtl/tick_gen_pkg.sv
// Shared constants for the tick generator: system clock rate, named channel
// divisors for the clock application, and an index-width helper.
package tick_gen_pkg;

    localparam int SYS_CLK_HZ = 100_000_000;

    // Base strobe of 1 kHz: seconds counter, setting-mode blink, display scan.
    localparam int DIV_1HZ   = 1000;
    localparam int DIV_BLINK = 250;
    localparam int DIV_SCAN  = 1;

    localparam int MAX_CH = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_chan.sv
// One tick channel: divides the shared base strobe by a runtime divisor.
// New divisors are taken only at a wrap or a sync clear, so no period is cut short.
module tick_chan
    import tick_gen_pkg::*;
#(
    parameter int               DIV_W   = 16,
    parameter logic [DIV_W-1:0] DIV_RST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_strobe,
    input  logic             i_sync_clr,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_wr_div,
    output logic             o_tick,
    output logic             o_sq,
    output logic             o_ack
);

    logic [DIV_W-1:0] r_q;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_shadow;
    logic             r_pend;
    logic             r_tick;
    logic             r_sq;
    logic             r_ack;
    logic             w_wrap;

    // A strobe that coincides with a sync clear is swallowed.
    assign w_wrap = i_strobe & ~i_sync_clr & (r_q == r_div - 1'b1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; later assignments in the block win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q      <= '0;
            r_div    <= DIV_RST;
            r_shadow <= DIV_RST;
            r_pend   <= 1'b0;
            r_tick   <= 1'b0;
            r_sq     <= 1'b0;
            r_ack    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_ack  <= 1'b0;
            if (i_sync_clr) begin
                r_q  <= '0;
                r_sq <= 1'b0;
                if (r_pend) begin
                    r_div  <= r_shadow;
                    r_pend <= 1'b0;
                    r_ack  <= 1'b1;
                end
            end else if (w_wrap) begin
                r_q    <= '0;
                r_tick <= 1'b1;
                r_sq   <= ~r_sq;
                if (r_pend) begin
                    r_div  <= r_shadow;
                    r_pend <= 1'b0;
                    r_ack  <= 1'b1;
                end
            end else if (i_strobe) begin
                r_q <= r_q + 1'b1;
            end
            // A write landing on the application edge stays pending for the next wrap.
            if (i_wr) begin
                r_shadow <= i_wr_div;
                r_pend   <= 1'b1;
            end
        end
    end

    assign o_tick = r_tick;
    assign o_sq   = r_sq;
    assign o_ack  = r_ack;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick generator: shared prescaler to BASE_HZ, divisor write
// decode with error pulse, and one tick_chan per channel.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int                        CLK_HZ   = SYS_CLK_HZ,
    parameter int                        BASE_HZ  = 1000,
    parameter int                        N_CH     = 3,
    parameter int                        DIV_W    = 16,
    parameter logic [N_CH*DIV_W-1:0]     DIV_INIT = {16'(DIV_SCAN), 16'(DIV_BLINK), 16'(DIV_1HZ)},
    localparam int                       CH_W     = idx_width(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             cfg_wr,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    output logic [N_CH-1:0]  cfg_ack,
    output logic             cfg_err,
    output logic             base_tick,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  sq
);

    localparam int                 PRE    = CLK_HZ / BASE_HZ;
    localparam int                 P_W    = (PRE > 1) ? $clog2(PRE) : 1;
    localparam logic [P_W-1:0]     P_LAST = P_W'(PRE - 1);
    localparam logic [CH_W:0]      N_CH_L = (CH_W + 1)'(N_CH);

    if (CLK_HZ % BASE_HZ != 0) begin : g_chk_ratio
        $error("tick_gen: CLK_HZ must be a multiple of BASE_HZ");
    end
    if (PRE < 2) begin : g_chk_pre
        $error("tick_gen: CLK_HZ/BASE_HZ must be at least 2");
    end
    if (N_CH < 1 || N_CH > MAX_CH) begin : g_chk_nch
        $error("tick_gen: N_CH must be in 1..8");
    end

    logic [P_W-1:0]  r_p;
    logic            r_base_tick;
    logic            r_cfg_err;
    logic            w_b;
    logic            w_cfg_ok;
    logic [N_CH-1:0] w_wr_sel;

    assign w_b      = en & (r_p == P_LAST);
    assign w_cfg_ok = (cfg_div != '0) && ({1'b0, cfg_ch} < N_CH_L);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_wr_sel = '0;
        if (cfg_wr && w_cfg_ok) begin
            w_wr_sel[cfg_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p         <= '0;
            r_base_tick <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_base_tick <= w_b & ~sync_clr;
            r_cfg_err   <= cfg_wr & ~w_cfg_ok;
            if (sync_clr) begin
                r_p <= '0;
            end else if (w_b) begin
                r_p <= '0;
            end else if (en) begin
                r_p <= r_p + 1'b1;
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        if (DIV_INIT[c*DIV_W +: DIV_W] == '0) begin : g_chk_div
            $error("tick_gen: DIV_INIT fields must be non-zero");
        end

        tick_chan #(
            .DIV_W   (DIV_W),
            .DIV_RST (DIV_INIT[c*DIV_W +: DIV_W])
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .i_strobe   (w_b),
            .i_sync_clr (sync_clr),
            .i_wr       (w_wr_sel[c]),
            .i_wr_div   (cfg_div),
            .o_tick     (tick[c]),
            .o_sq       (sq[c]),
            .o_ack      (cfg_ack[c])
        );
    end

    assign base_tick = r_base_tick;
    assign cfg_err   = r_cfg_err;

endmodule
